// File: rtl/fifo_pkg.sv
// Shared width helpers for the FIFO controller and its storage.
package fifo_pkg;

    // Entry index width; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bit-offset width covering DATA_WIDTH*DEPTH bits of storage.
    function automatic int unsigned addr_width(input int unsigned data_width,
                                               input int unsigned depth);
        return (data_width * depth > 1) ? $clog2(data_width * depth) : 1;
    endfunction

    // Occupancy width; must be able to hold the value DEPTH itself.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_pointer.sv
// Entry pointer with a companion bit-address counter; wraps at DEPTH-1.
module fifo_pointer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        en_i,
    input  logic                                        clr_i,
    output logic [ptr_width(DEPTH)-1:0]                 ptr_o,
    output logic [addr_width(DATA_WIDTH, DEPTH)-1:0]    addr_o
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = addr_width(DATA_WIDTH, DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] addr_q, addr_d;

    // Next pointer/address: clear wins, then advance with explicit wrap so
    // non-power-of-two depths work.
    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        if (clr_i) begin
            ptr_d  = '0;
            addr_d = '0;
        end else if (en_i) begin
            if (ptr_q == PW'(DEPTH - 1)) begin
                ptr_d  = '0;
                addr_d = '0;
            end else begin
                ptr_d  = ptr_q + PW'(1);
                addr_d = addr_q + AW'(DATA_WIDTH);
            end
        end
    end

    // Pointer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            addr_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/fifo_controller.sv
// FIFO control: qualified push/pop strobes, pointers, occupancy and
// sticky overflow/underflow flags.
module fifo_controller
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned DEPTH             = 8,
    parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        write_request,
    input  logic                                        read_request,
    input  logic                                        flush,
    input  logic                                        clear_errors,
    output logic                                        write_enable,
    output logic                                        read_enable,
    output logic [ptr_width(DEPTH)-1:0]                 write_pointer,
    output logic [ptr_width(DEPTH)-1:0]                 read_pointer,
    output logic [addr_width(DATA_WIDTH, DEPTH)-1:0]    write_address,
    output logic [addr_width(DATA_WIDTH, DEPTH)-1:0]    read_address,
    output logic [lvl_width(DEPTH)-1:0]                 level,
    output logic                                        full,
    output logic                                        empty,
    output logic                                        almost_full,
    output logic                                        overflow,
    output logic                                        underflow
);

    localparam int unsigned LW = lvl_width(DEPTH);

    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    // Qualified strobes; gated by reset so nothing reaches storage while held.
    always_comb begin
        write_enable = reset & write_request & ~full_q & ~flush;
        read_enable  = reset & read_request & ~empty_q & ~flush;
    end

    fifo_pointer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_wr_ptr (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (write_enable),
        .clr_i  (flush),
        .ptr_o  (write_pointer),
        .addr_o (write_address)
    );

    fifo_pointer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_ptr (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (read_enable),
        .clr_i  (flush),
        .ptr_o  (read_pointer),
        .addr_o (read_address)
    );

    // Next occupancy and flags; status flags are derived from the next level
    // so they are registered alongside it.
    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            unique case ({write_enable, read_enable})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        full_d        = (32'(level_d) == DEPTH);
        empty_d       = (level_d == '0);
        almost_full_d = (32'(level_d) >= ALMOST_FULL_LEVEL);
        // Sticky errors: a new error beats a simultaneous clear.
        overflow_d    = (write_request & full_q) | (overflow_q & ~clear_errors);
        underflow_d   = (read_request & empty_q) | (underflow_q & ~clear_errors);
    end

    // Occupancy and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            level_q       <= level_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign level       = level_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_controller.sv
// Bench for fifo_controller: an occupancy/count model for two configurations
// (8x8 and 6x12), per-cycle comparison plus directed literal expectations.
module tb_fifo_controller;
    import fifo_pkg::*;

    localparam int DEP [2] = '{8, 6};
    localparam int DW  [2] = '{8, 12};
    localparam int AFL [2] = '{6, 4};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic wr [2];
    logic rd [2];
    logic fl [2];
    logic ce [2];

    logic                          we0, re0, fu0, em0, af0, ov0, un0;
    logic [ptr_width(8)-1:0]       wp0, rp0;
    logic [addr_width(8, 8)-1:0]   wa0, ra0;
    logic [lvl_width(8)-1:0]       lv0;

    logic                          we1, re1, fu1, em1, af1, ov1, un1;
    logic [ptr_width(6)-1:0]       wp1, rp1;
    logic [addr_width(12, 6)-1:0]  wa1, ra1;
    logic [lvl_width(6)-1:0]       lv1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: occupancy, pushes/pops since reset or flush, sticky errors.
    int m_lvl [2] = '{0, 0};
    int m_wc  [2] = '{0, 0};
    int m_rc  [2] = '{0, 0};
    int m_ov  [2] = '{0, 0};
    int m_un  [2] = '{0, 0};

    always #5 clk = ~clk;

    fifo_controller #(.DATA_WIDTH(8), .DEPTH(8)) u_dut0 (
        .clk (clk), .reset (rst_n),
        .write_request (wr[0]), .read_request (rd[0]),
        .flush (fl[0]), .clear_errors (ce[0]),
        .write_enable (we0), .read_enable (re0),
        .write_pointer (wp0), .read_pointer (rp0),
        .write_address (wa0), .read_address (ra0),
        .level (lv0), .full (fu0), .empty (em0), .almost_full (af0),
        .overflow (ov0), .underflow (un0)
    );

    fifo_controller #(.DATA_WIDTH(12), .DEPTH(6)) u_dut1 (
        .clk (clk), .reset (rst_n),
        .write_request (wr[1]), .read_request (rd[1]),
        .flush (fl[1]), .clear_errors (ce[1]),
        .write_enable (we1), .read_enable (re1),
        .write_pointer (wp1), .read_pointer (rp1),
        .write_address (wa1), .read_address (ra1),
        .level (lv1), .full (fu1), .empty (em1), .almost_full (af1),
        .overflow (ov1), .underflow (un1)
    );

    function automatic int exp_we(input int d);
        return (rst_n && wr[d] && !fl[d] && m_lvl[d] < DEP[d]) ? 1 : 0;
    endfunction

    function automatic int exp_re(input int d);
        return (rst_n && rd[d] && !fl[d] && m_lvl[d] > 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_lvl[d] <= 0; m_wc[d] <= 0; m_rc[d] <= 0;
                m_ov[d]  <= 0; m_un[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_ov[d] <= ((wr[d] && m_lvl[d] == DEP[d]) || (m_ov[d] != 0 && !ce[d])) ? 1 : 0;
                m_un[d] <= ((rd[d] && m_lvl[d] == 0) || (m_un[d] != 0 && !ce[d])) ? 1 : 0;
                if (fl[d]) begin
                    m_lvl[d] <= 0; m_wc[d] <= 0; m_rc[d] <= 0;
                end else begin
                    m_wc[d]  <= m_wc[d] + exp_we(d);
                    m_rc[d]  <= m_rc[d] + exp_re(d);
                    m_lvl[d] <= m_lvl[d] + exp_we(d) - exp_re(d);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input int we, input int re, input int wp, input int rp,
                           input int wa, input int ra, input int lv, input int fu, input int em,
                           input int af, input int ov, input int un);
        int wpe, rpe;
        wpe = m_wc[d] % DEP[d];
        rpe = m_rc[d] % DEP[d];
        chk($sformatf("d%0d write_enable", d), we, exp_we(d));
        chk($sformatf("d%0d read_enable", d), re, exp_re(d));
        chk($sformatf("d%0d write_pointer", d), wp, wpe);
        chk($sformatf("d%0d read_pointer", d), rp, rpe);
        chk($sformatf("d%0d write_address", d), wa, wpe * DW[d]);
        chk($sformatf("d%0d read_address", d), ra, rpe * DW[d]);
        chk($sformatf("d%0d level", d), lv, m_lvl[d]);
        chk($sformatf("d%0d full", d), fu, (m_lvl[d] == DEP[d]) ? 1 : 0);
        chk($sformatf("d%0d empty", d), em, (m_lvl[d] == 0) ? 1 : 0);
        chk($sformatf("d%0d almost_full", d), af, (m_lvl[d] >= AFL[d]) ? 1 : 0);
        chk($sformatf("d%0d overflow", d), ov, m_ov[d]);
        chk($sformatf("d%0d underflow", d), un, m_un[d]);
    endtask

    // One cycle: compare everything against the model mid-cycle, then move to
    // just after the next rising edge.
    task automatic step();
        @(negedge clk);
        cmp_dut(0, int'(we0), int'(re0), int'(wp0), int'(rp0), int'(wa0), int'(ra0),
                int'(lv0), int'(fu0), int'(em0), int'(af0), int'(ov0), int'(un0));
        cmp_dut(1, int'(we1), int'(re1), int'(wp1), int'(rp1), int'(wa1), int'(ra1),
                int'(lv1), int'(fu1), int'(em1), int'(af1), int'(ov1), int'(un1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ra_exp [7];
        int max_lvl;
        ra_exp = '{0, 12, 24, 36, 48, 60, 0};
        for (int d = 0; d < 2; d++) begin
            wr[d] = 1'b0; rd[d] = 1'b0; fl[d] = 1'b0; ce[d] = 1'b0;
        end

        // Reset state, with a write request held to show the strobe is gated.
        #2 rst_n = 1'b0;
        wr[0] = 1'b1;
        #1;
        chk("rst write_enable", int'(we0), 0);
        chk("rst level", int'(lv0), 0);
        chk("rst empty", int'(em0), 1);
        chk("rst full", int'(fu0), 0);
        chk("rst almost_full", int'(af0), 0);
        step();
        step();
        wr[0] = 1'b0;
        rst_n = 1'b1;
        step();

        // Fill: level 1..8, almost_full from 6, full and wrapped pointer at 8.
        for (int i = 1; i <= 8; i++) begin
            wr[0] = 1'b1;
            step();
            chk("fill level", int'(lv0), i);
            chk("fill almost_full", int'(af0), (i >= 6) ? 1 : 0);
        end
        wr[0] = 1'b0;
        chk("fill full", int'(fu0), 1);
        chk("fill write_pointer", int'(wp0), 0);
        chk("fill write_address", int'(wa0), 0);

        // Full with both requests: read only, overflow next cycle, then clear.
        wr[0] = 1'b1; rd[0] = 1'b1;
        #1;
        chk("full wr+rd write_enable", int'(we0), 0);
        chk("full wr+rd read_enable", int'(re0), 1);
        step();
        wr[0] = 1'b0; rd[0] = 1'b0;
        chk("full wr+rd level", int'(lv0), 7);
        chk("full wr+rd overflow", int'(ov0), 1);
        ce[0] = 1'b1;
        step();
        ce[0] = 1'b0;
        chk("overflow cleared", int'(ov0), 0);

        // Drain to empty.
        rd[0] = 1'b1;
        repeat (7) step();
        rd[0] = 1'b0;
        chk("drain empty", int'(em0), 1);

        // Empty with both requests: write only, underflow, then clear.
        wr[0] = 1'b1; rd[0] = 1'b1;
        #1;
        chk("empty wr+rd read_enable", int'(re0), 0);
        chk("empty wr+rd write_enable", int'(we0), 1);
        step();
        wr[0] = 1'b0; rd[0] = 1'b0;
        chk("empty wr+rd level", int'(lv0), 1);
        chk("empty wr+rd underflow", int'(un0), 1);
        ce[0] = 1'b1;
        step();
        ce[0] = 1'b0;
        chk("underflow cleared", int'(un0), 0);

        // Level 5 then flush with a write request.
        wr[0] = 1'b1;
        repeat (4) step();
        wr[0] = 1'b0;
        chk("pre-flush level", int'(lv0), 5);
        wr[0] = 1'b1; fl[0] = 1'b1;
        #1;
        chk("flush write_enable", int'(we0), 0);
        step();
        wr[0] = 1'b0; fl[0] = 1'b0;
        chk("flush level", int'(lv0), 0);
        chk("flush empty", int'(em0), 1);
        chk("flush write_pointer", int'(wp0), 0);
        chk("flush read_pointer", int'(rp0), 0);
        chk("flush write_address", int'(wa0), 0);
        chk("flush read_address", int'(ra0), 0);

        // Non-power-of-two depth: 7 interleaved write/read pairs.
        max_lvl = 0;
        for (int i = 0; i < 7; i++) begin
            wr[1] = 1'b1;
            step();
            wr[1] = 1'b0;
            if (int'(lv1) > max_lvl) max_lvl = int'(lv1);
            rd[1] = 1'b1;
            #1;
            chk($sformatf("d1 read_address #%0d", i), int'(ra1), ra_exp[i]);
            step();
            rd[1] = 1'b0;
            if (int'(lv1) > max_lvl) max_lvl = int'(lv1);
        end
        chk("d1 max level", max_lvl, 1);
        chk("d1 final read_pointer", int'(rp1), 1);

        // Reset mid-stream at level 4.
        wr[0] = 1'b1;
        repeat (4) step();
        wr[0] = 1'b0;
        chk("pre-reset level", int'(lv0), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset level", int'(lv0), 0);
        chk("async reset empty", int'(em0), 1);
        chk("async reset write_pointer", int'(wp0), 0);
        chk("async reset write_address", int'(wa0), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post-reset level", int'(lv0), 0);
        wr[0] = 1'b1;
        step();
        wr[0] = 1'b0;
        chk("post-reset write level", int'(lv0), 1);
        chk("post-reset write_pointer", int'(wp0), 1);
        chk("post-reset write_address", int'(wa0), 8);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
